// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants.
// Used by aes_key_expander and its key_step datapath.
package aes_pkg;

  localparam int AES_NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRECOMP,
    S_EMIT
  } keyexp_state_t;

  function automatic logic [7:0] rcon_f(
    input logic [3:0] r
  );
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= AES_NR; i++)
      if (r == i[3:0]) v = RCON[i];
    return v;
  endfunction

endpackage

// File: rtl/aes_key_expander_key_step.sv
// key_step: one forward or reverse AES-128 key-schedule step.
// Reverse shares the single sub_word by feeding it the recovered w3.
module key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   rnd_i,
  input  logic         fwd_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t3, rot_in, sw_in, sw;
  logic [31:0] rc, n0, n1, n2, n3;
  logic [3:0]  r;

  assign {w0, w1, w2, w3} = key_i;

  sub_word u_sub_word (
    .word_i       (sw_in),
    .enc_or_dec_i (1'b1),
    .word_o       (sw)
  );

  always_comb begin
    t3     = w3 ^ w2;
    rot_in = fwd_i ? w3 : t3;
    sw_in  = {rot_in[23:0], rot_in[31:24]};
    r      = fwd_i ? rnd_i + 4'd1 : rnd_i;
    rc     = {rcon_f(r), 24'h0};
    n0     = w0 ^ sw ^ rc;
    n1     = w1 ^ n0;
    n2     = w2 ^ n1;
    n3     = w3 ^ n2;
    if (fwd_i)
      key_o = {n0, n1, n2, n3};
    else
      key_o = {n0, w1 ^ w0, w2 ^ w1, t3};
  end

endmodule

// File: rtl/sub_word.sv
// Four parallel AES S-boxes (forward or inverse).
// Built from the GF(2^8) inverse plus the affine map, not a ROM table.
module sub_word (
  input  logic [31:0] word_i,
  input  logic        enc_or_dec_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl(v, 1) ^ rotl(v, 2)
             ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] s
  );
    logic [7:0] v;
    v = rotl(s, 1) ^ rotl(s, 3)
      ^ rotl(s, 6) ^ 8'h05;
    return gf_inv(v);
  endfunction

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++)
      word_o[i*8 +: 8] = enc_or_dec_i
        ? sbox(word_i[i*8 +: 8])
        : inv_sbox(word_i[i*8 +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expander streaming round keys by handshake.
// Optional round-10 cache: define AES_KEYEXP_CACHE_EN.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         enc_or_dec_i,
  output logic [127:0] rkey_o,
  output logic [3:0]   rnd_o,
  output logic         rkey_valid_o,
  input  logic         rkey_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] LAST = 4'(NR);

  keyexp_state_t state_q;
  logic [127:0]  key_q, key_d;
  logic [3:0]    rnd_q;
  logic          dir_q;
  logic          valid_q, busy_q, done_q;
  logic          step_fwd, last_key;

`ifdef AES_KEYEXP_CACHE_EN
  logic [127:0] orig_q, cache_key_q, cache_r10_q;
  logic         cache_vld_q;
  logic         cache_hit;
  assign cache_hit = cache_vld_q
                   && (key_i == cache_key_q);
`endif

  assign step_fwd = (state_q == S_PRECOMP) | dir_q;
  assign last_key = dir_q ? (rnd_q == LAST)
                          : (rnd_q == 4'd0);

  key_step u_key_step (
    .key_i (key_q),
    .rnd_i (rnd_q),
    .fwd_i (step_fwd),
    .key_o (key_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      dir_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEYEXP_CACHE_EN
      orig_q      <= '0;
      cache_key_q <= '0;
      cache_r10_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            key_q  <= key_i;
            rnd_q  <= 4'd0;
            dir_q  <= enc_or_dec_i;
            busy_q <= 1'b1;
`ifdef AES_KEYEXP_CACHE_EN
            orig_q <= key_i;
`endif
            if (enc_or_dec_i) begin
              state_q <= S_EMIT;
              valid_q <= 1'b1;
`ifdef AES_KEYEXP_CACHE_EN
            end else if (cache_hit) begin
              key_q   <= cache_r10_q;
              rnd_q   <= LAST;
              state_q <= S_EMIT;
              valid_q <= 1'b1;
`endif
            end else begin
              state_q <= S_PRECOMP;
            end
          end
        end
        S_PRECOMP: begin
          key_q <= key_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == LAST - 4'd1) begin
            state_q <= S_EMIT;
            valid_q <= 1'b1;
`ifdef AES_KEYEXP_CACHE_EN
            cache_key_q <= orig_q;
            cache_r10_q <= key_d;
            cache_vld_q <= 1'b1;
`endif
          end
        end
        S_EMIT: begin
          if (rkey_ready_i) begin
            if (last_key) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q <= key_d;
              rnd_q <= dir_q ? rnd_q + 4'd1
                             : rnd_q - 4'd1;
`ifdef AES_KEYEXP_CACHE_EN
              if (dir_q && rnd_q == LAST - 4'd1) begin
                cache_key_q <= orig_q;
                cache_r10_q <= key_d;
                cache_vld_q <= 1'b1;
              end
`endif
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rkey_o       = key_q;
  assign rnd_o        = rnd_q;
  assign rkey_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander (FIPS-197 vectors).
// Define AES_KEYEXP_CACHE_EN to also exercise the round-10 cache.
module tb_aes_key_expander;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic [127:0] mask;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         enc_or_dec_i = 1'b1;
  logic [127:0] rkey_o;
  logic [3:0]   rnd_o;
  logic         rkey_valid_o;
  logic         rkey_ready_i = 1'b1;
  logic         busy_o;
  logic         done_o;

  int n_cmp = 0;
  int n_err = 0;

  exp_t         sb[$];
  logic [127:0] fips [0:10];
  logic [127:0] fkey;
  logic         bp_en = 1'b0;
  logic         rs_pend = 1'b0;
  logic         held = 1'b0;
  logic [127:0] h_key;
  logic [3:0]   h_rnd;

`ifdef AES_KEYEXP_CACHE_EN
  localparam int DEC_LAT = 1;
  localparam int DEC_CYC = 12;
`else
  localparam int DEC_LAT = 11;
  localparam int DEC_CYC = 22;
`endif

  aes_key_expander dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .key_i        (key_i),
    .enc_or_dec_i (enc_or_dec_i),
    .rkey_o       (rkey_o),
    .rnd_o        (rnd_o),
    .rkey_valid_o (rkey_valid_o),
    .rkey_ready_i (rkey_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops on handshake, checks hold under back-pressure
  always @(negedge clk) begin
    if (rkey_valid_o) begin
      if (held) begin
        check("hold_key", rkey_o, h_key);
        check("hold_rnd", 128'(rnd_o), 128'(h_rnd));
      end
      if (rkey_ready_i) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty: got rnd %0d want none",
                   rnd_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rnd", 128'(rnd_o), 128'(e.rnd));
          check("rkey", rkey_o & e.mask, e.key & e.mask);
        end
      end else begin
        held  = 1'b1;
        h_key = rkey_o;
        h_rnd = rnd_o;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Random ready and stray start pulses while busy
  always @(posedge clk) begin
    #2;
    if (rs_pend) begin
      start_i = 1'b0;
      rs_pend = 1'b0;
    end
    if (bp_en) begin
      rkey_ready_i = ($urandom_range(0, 2) != 0);
      if (busy_o && $urandom_range(0, 3) == 0) begin
        start_i      = 1'b1;
        enc_or_dec_i = 1'($urandom_range(0, 1));
        key_i        = {4{$urandom}};
        rs_pend      = 1'b1;
      end
    end
  end

  task automatic push_fips(input logic fwd);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      int k;
      k      = fwd ? i : 10 - i;
      e.rnd  = 4'(k);
      e.key  = fips[k];
      e.mask = '1;
      sb.push_back(e);
    end
  endtask

  task automatic push_zero();
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.rnd  = 4'(i);
      e.key  = '0;
      e.mask = '0;
      if (i == 0 || i == 1 || i == 10) e.mask = '1;
      if (i == 1) e.key = {4{32'h62636363}};
      if (i == 10)
        e.key = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
      sb.push_back(e);
    end
  endtask

  task automatic run(
    input logic [127:0] k,
    input logic         enc,
    input int           exp_lat,
    input int           exp_cyc
  );
    int lat;
    @(posedge clk);
    #1;
    start_i      = 1'b1;
    key_i        = k;
    enc_or_dec_i = enc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    key_i   = {4{$urandom}};
    lat     = 1;
    while (!rkey_valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("valid_seen", 128'(rkey_valid_o), 128'd1);
    if (exp_lat >= 0)
      check("latency", 128'(lat), 128'(exp_lat));
    while (!done_o && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", 128'(done_o), 128'd1);
    if (exp_cyc >= 0)
      check("cyc_to_done", 128'(lat), 128'(exp_cyc));
    check("sb_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    int w;
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fkey     = fips[0];

    repeat (3) @(posedge clk);
    #1;
    check("rst_rkey", rkey_o, '0);
    check("rst_rnd", 128'(rnd_o), '0);
    check("rst_valid", 128'(rkey_valid_o), '0);
    check("rst_busy", 128'(busy_o), '0);
    check("rst_done", 128'(done_o), '0);
    rst_i = 1'b0;

    push_fips(1'b1);
    run(fkey, 1'b1, 1, 12);

    push_fips(1'b0);
    run(fkey, 1'b0, DEC_LAT, DEC_CYC);

    push_zero();
    run('0, 1'b1, 1, 12);

    push_fips(1'b0);
    bp_en = 1'b1;
    run(fkey, 1'b0, -1, -1);
    bp_en = 1'b0;
    @(posedge clk);
    #3;
    rkey_ready_i = 1'b1;

    push_fips(1'b1);
    @(posedge clk);
    #1;
    start_i      = 1'b1;
    key_i        = fkey;
    enc_or_dec_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    w = 0;
    while (rnd_o != 4'd5 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("reach_rnd5", 128'(rnd_o), 128'd5);
    rst_i = 1'b1;
    #1;
    check("mid_rst_rkey", rkey_o, '0);
    check("mid_rst_rnd", 128'(rnd_o), '0);
    check("mid_rst_valid", 128'(rkey_valid_o), '0);
    check("mid_rst_busy", 128'(busy_o), '0);
    @(posedge clk);
    #1;
    check("mid_rst_done", 128'(done_o), '0);
    sb.delete();
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_done", 128'(done_o), '0);

    push_fips(1'b1);
    run(fkey, 1'b1, 1, 12);

`ifdef AES_KEYEXP_CACHE_EN
    push_fips(1'b0);
    run(fkey, 1'b0, 1, 12);
`endif

    push_zero();
    sb.delete();
    for (int i = 10; i >= 0; i--) begin
      exp_t e;
      e.rnd  = 4'(i);
      e.key  = '0;
      e.mask = '0;
      if (i == 0) e.mask = '1;
      if (i == 1) begin
        e.key  = {4{32'h62636363}};
        e.mask = '1;
      end
      if (i == 10) begin
        e.key  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        e.mask = '1;
      end
      sb.push_back(e);
    end
    run('0, 1'b0, 11, 22);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key-schedule engine. It produces the 11 round keys on demand, one 128-bit round key per handshake, using the `sub_word` S-box stage for the SubWord step. It sits directly upstream of the round datapath.
- **Encrypt:** round keys stream in forward order, 0..10.
- **Decrypt:** the engine first expands to round 10, then streams the keys in reverse order, 10..0, using the inverse key recurrence. No 176-byte key RAM is needed.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `start_i`, input, 1: begin expansion of `key_i`. Sampled only in IDLE.
- `key_i`, input, 128: cipher key. Word 0 is `[127:96]`.
- `enc_or_dec_i`, input, 1: 1 = forward order, 0 = reverse order. Sampled with `start_i`.
- `rkey_o`, output, 128: current round key.
- `rnd_o`, output, 4: round index of `rkey_o`, 0..10.
- `rkey_valid_o`, output, 1: `rkey_o` and `rnd_o` are valid.
- `rkey_ready_i`, input, 1: consumer accepts the round key.
- `busy_o`, output, 1: high in every state except IDLE.
- `done_o`, output, 1: one-cycle pulse after the final round key is accepted.

## Operation
- States: IDLE, PRECOMP, EMIT.
- **IDLE:**
  - On `start_i`: load `key_i` into the key register, set `rnd` = 0, latch the direction.
  - Encrypt goes to EMIT; decrypt goes to PRECOMP.
- **PRECOMP** (decrypt only):
  - Each cycle, key register ← forward step, `rnd` += 1.
  - After the step that makes `rnd` = 10, go to EMIT.
- **EMIT:**
  - `rkey_valid_o` = 1.
  - On `valid && ready`:
    - Final key (`rnd` 10 for encrypt, 0 for decrypt): go to IDLE and pulse `done_o` in the next cycle.
    - Otherwise: key register ← next step (forward or reverse) and `rnd` ± 1 in the same edge. Valid stays high, so throughput is one key per cycle.
- **Forward step**, for round r = `rnd`+1:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ RCON[r]
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- **Reverse step**, from round r = `rnd`:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ RCON[r]
- RCON[r] occupies the top byte only: RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord always uses the forward S-box: `sub_word`'s `enc_or_dec_i` is tied to 1.
- All arithmetic is bitwise XOR at 32-bit width. No carries.
- `start_i` outside IDLE is ignored. `key_i` changes after start have no effect.
- While valid is high and ready is low, `rkey_o` and `rnd_o` hold stable.

## Timing
- Reset values:
  - State IDLE.
  - `rkey_o` = 0, `rnd_o` = 0.
  - `rkey_valid_o`, `busy_o`, `done_o` = 0.
- Reset asserted mid-operation aborts immediately to IDLE. No `done_o` is issued.
- Encrypt: start sampled at edge E0 → valid from E0 onward. Latency 1 cycle.
- Decrypt: PRECOMP runs on edges E1..E10 → valid after E10. Latency 11 cycles.
- Minimum key-to-key time is 11 cycles for encrypt with `ready` held high, then IDLE for one cycle before the next start.
- `done_o` is high in the cycle after the last handshake. `start_i` in that cycle is accepted.

## Configuration
- Macro: `AES_KEYEXP_CACHE_EN`.
- **Defined:** the block keeps a 128-bit cache key, a 128-bit cache round-10 key, and a valid flag.
  - The cache is written whenever round 10 is reached in either direction.
  - A decrypt start whose `key_i` equals a valid cache key loads the round-10 value, sets `rnd` = 10, and goes straight to EMIT. Latency is 1 cycle.
  - Reset clears the valid flag.
- **Undefined:** no cache storage. Decrypt always runs PRECOMP.

## Structure
- Package `aes_pkg` holds:
  - `AES_NR` = 10
  - the RCON constant array, indexed 1..10
  - the state enum `keyexp_state_t`
- Sub-module `key_step`: combinational forward/reverse round function, with inputs key, round and direction. It contains the single `sub_word` instance.
- The top level holds the FSM, the registers, the handshake and the optional cache.

## Test plan
- **FIPS-197 key, encrypt, ready held high.**
  - Key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - rnd 1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - rnd 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - 11 consecutive valid cycles, then `done_o`.
- **Same key, decrypt.**
  - Valid 11 cycles after start.
  - Sequence: rnd 10 = d014f9a8…, …, rnd 0 = 2b7e1516…
- **All-zero key, encrypt.**
  - rnd 1 = 62636363 ×4.
  - rnd 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- **Random ready back-pressure, decrypt.**
  - `rkey_o` and `rnd_o` stable while ready is low.
  - The order and values match the previous test.
  - `start_i` pulses while busy are ignored.
- **Reset at rnd 5 of encrypt.**
  - All outputs are at reset values next cycle. No `done_o`.
  - A fresh start then behaves normally.
- **With `AES_KEYEXP_CACHE_EN`.**
  - Encrypt the FIPS key, then decrypt the same key: valid after 1 cycle with d014f9a8…
  - A different key runs the full 11-cycle latency.
